// File: rtl/led_pwm_fader_pkg.sv
// Shared definitions for the LED PWM fader: default PWM width, the full-scale
// brightness constant, the level type and the saturating fade-step helper.
package led_pkg;

    localparam int PWM_BITS = 8;
    localparam int LVL_MAX  = (1 << PWM_BITS) - 1;

    typedef logic [PWM_BITS-1:0] lvl_t;

    // Move lvl one fade step towards max (up=1) or towards zero (up=0),
    // clamping at either end. Operands are zero-extended by callers, and the
    // sum carries one extra bit, so the level can never wrap around.
    function automatic logic [31:0] sat_step(input logic [31:0] lvl,
                                             input logic        up,
                                             input logic [31:0] step,
                                             input logic [31:0] max);
        logic [32:0] sum_v;
        logic [32:0] res_v;
        sum_v = {1'b0, lvl} + {1'b0, step};
        if (up) begin
            res_v = (sum_v > {1'b0, max}) ? {1'b0, max} : sum_v;
        end else begin
            res_v = (lvl > step) ? {1'b0, lvl - step} : 33'd0;
        end
        return res_v[31:0];
    endfunction

endpackage

// File: rtl/led_pwm_fader_if.sv
// Pattern-in / pins-out bundle between the pattern generator (master) and the
// fader (slave).
interface led_pwm_fader_if #(parameter int N_LED = 5);
    logic [N_LED-1:0] pattern_in;
    logic             pattern_valid;
    logic [N_LED-1:0] led;
    logic             busy;

    modport master (output pattern_in, output pattern_valid, input led, input busy);
    modport slave  (input pattern_in, input pattern_valid, output led, output busy);
endinterface

// File: rtl/led_pwm_fader_channel.sv
// One LED channel: fading brightness level, period-aligned duty shadow and the
// registered PWM pin. Optional macro LED_PWM_FADER_GAMMA_EN selects a squared
// brightness curve for the duty shadow; without it the duty is the raw level.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int FADE_STEP = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_i,
    input  logic                pwm_wrap_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    input  logic                target_i,
    input  logic                target_nxt_i,
    output logic                led_o,
    output logic                at_target_o
);

    localparam logic [PWM_BITS-1:0] MAX_L  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] ZERO_L = {PWM_BITS{1'b0}};

    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] lvl_f_s;
    logic                led_q, led_d;

`ifdef LED_PWM_FADER_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq_s;

    // Perceptual curve: level squared scaled back to PWM range, full scale kept exact.
    always_comb begin
        sq_s = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};
        if (level_q == MAX_L) begin
            lvl_f_s = MAX_L;
        end else begin
            lvl_f_s = PWM_BITS'(sq_s >> PWM_BITS);
        end
    end
`else
    // Linear curve: duty follows the level directly.
    always_comb begin
        lvl_f_s = level_q;
    end
`endif

    // Next-state: level steps only on fade ticks, duty reloads only at the PWM
    // period boundary so a running period is never cut short.
    always_comb begin
        if (tick_i) begin
            level_d = PWM_BITS'(sat_step(32'(level_q), target_i, 32'(FADE_STEP), 32'(MAX_L)));
        end else begin
            level_d = level_q;
        end
        if (pwm_wrap_i) begin
            duty_d = lvl_f_s;
        end else begin
            duty_d = duty_q;
        end
        led_d       = (duty_q == MAX_L) | (duty_q > pwm_cnt_i);
        at_target_o = (level_d == (target_nxt_i ? MAX_L : ZERO_L));
    end

    // Channel state flops, cleared immediately by reset so the pin goes dark at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= ZERO_L;
            duty_q  <= ZERO_L;
            led_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            duty_q  <= duty_d;
            led_q   <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_pwm_fader.sv
// LED PWM fader top: captures the on/off pattern, runs the fade prescaler and
// the shared PWM counter, and fans out to one channel per LED.
// Optional macro LED_PWM_FADER_GAMMA_EN enables a gamma-2 duty curve.
module led_pwm_fader
    import led_pkg::*;
#(
    parameter int N_LED     = 5,
    parameter int PWM_BITS  = led_pkg::PWM_BITS,
    parameter int FADE_DIV  = 4096,
    parameter int FADE_STEP = 16
) (
    input logic                  clk,
    input logic                  rst,
    led_pwm_fader_if.slave       bus
);

    localparam int                  PRESC_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(FADE_DIV - 1);
    localparam logic [PWM_BITS-1:0] MAX_L      = {PWM_BITS{1'b1}};

    logic [N_LED-1:0]    target_q, target_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                busy_q, busy_d;
    logic                tick_s;
    logic                pwm_wrap_s;
    logic [N_LED-1:0]    led_s;
    logic [N_LED-1:0]    at_target_s;

    assign tick_s     = (presc_q == PRESC_LAST);
    assign pwm_wrap_s = (pwm_cnt_q == MAX_L);

    // Next-state for pattern target, fade prescaler, PWM counter and busy flag.
    always_comb begin
        if (bus.pattern_valid) begin
            target_d = bus.pattern_in;
        end else begin
            target_d = target_q;
        end
        if (tick_s) begin
            presc_d = {PRESC_W{1'b0}};
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        busy_d    = ~(&at_target_s);
    end

    // Shared control flops; all clear asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q  <= {N_LED{1'b0}};
            presc_q   <= {PRESC_W{1'b0}};
            pwm_cnt_q <= {PWM_BITS{1'b0}};
            busy_q    <= 1'b0;
        end else begin
            target_q  <= target_d;
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            busy_q    <= busy_d;
        end
    end

    for (genvar i = 0; i < N_LED; i++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS (PWM_BITS),
            .FADE_STEP(FADE_STEP)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tick_i      (tick_s),
            .pwm_wrap_i  (pwm_wrap_s),
            .pwm_cnt_i   (pwm_cnt_q),
            .target_i    (target_q[i]),
            .target_nxt_i(target_d[i]),
            .led_o       (led_s[i]),
            .at_target_o (at_target_s[i])
        );
    end

    assign bus.led  = led_s;
    assign bus.busy = busy_q;

endmodule
